// File: rtl/rv32_decode_pkg.sv
// Shared opcode constants and immediate-format selection for the RV32IM decode stage.
// The custom-0 opcode carries the encryption extension; it writes rd but has no immediate.
package rv32_decode_pkg;

    localparam logic [6:0] OP_R       = 7'h33;
    localparam logic [6:0] OP_IMM     = 7'h13;
    localparam logic [6:0] OP_LOAD    = 7'h03;
    localparam logic [6:0] OP_STORE   = 7'h23;
    localparam logic [6:0] OP_BRANCH  = 7'h63;
    localparam logic [6:0] OP_JAL     = 7'h6F;
    localparam logic [6:0] OP_JALR    = 7'h67;
    localparam logic [6:0] OP_LUI     = 7'h37;
    localparam logic [6:0] OP_AUIPC   = 7'h17;
    localparam logic [6:0] OP_SYSTEM  = 7'h73;
    localparam logic [6:0] OP_CUSTOM0 = 7'h0B;

    // Opcodes whose result lands in rd.
    localparam int NUM_WB_OPS = 9;
    localparam logic [6:0] WB_OPCODES [NUM_WB_OPS] = '{
        OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_CUSTOM0
    };

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
        imm_fmt_e fmt;
        fmt = IMM_NONE;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = IMM_I;
            OP_STORE:                            fmt = IMM_S;
            OP_BRANCH:                           fmt = IMM_B;
            OP_LUI, OP_AUIPC:                    fmt = IMM_U;
            OP_JAL:                              fmt = IMM_J;
            default:                             fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Immediate generator: picks the encoding from the opcode and sign-extends to 32 bits.
// R-type and custom-0 produce zero.
module rv32_imm_gen
    import rv32_decode_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [31:0] imm32
);

    imm_fmt_e fmt;
    assign fmt = imm_fmt_of(instruction[6:0]);

    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            IMM_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
            IMM_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            IMM_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            IMM_U: imm32 = {instruction[31:12], 12'd0};
            IMM_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32IM decode stage: field split, immediate, jump/branch target and static fetch redirect.
// Define DECODER_BRANCH_PREDICT_EN to predict backward branches taken (with loop-exit override).
module rv32_decode_stage
    import rv32_decode_pkg::*;
#(
    parameter int ADDRESS_BITS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] pc,
    input  logic [31:0]             instruction,
    input  logic [ADDRESS_BITS-1:0] pc_next,
    input  logic                    branch,
    input  logic                    out_of_loop_i,
    output logic [ADDRESS_BITS-1:0] target_pc,
    output logic [6:0]              op,
    output logic [2:0]              funct3,
    output logic [6:0]              funct7,
    output logic                    pc_s_d,
    output logic [4:0]              read_sel1,
    output logic [4:0]              read_sel2,
    output logic [4:0]              write_sel,
    output logic                    wen,
    output logic [31:0]             imm32,
    output logic [ADDRESS_BITS-1:0] pc_next_o,
    output logic [ADDRESS_BITS-1:0] pc_o,
    output logic [11:0]             imm12
);

    assign op        = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7    = instruction[31:25];
    assign read_sel1 = instruction[19:15];
    assign read_sel2 = instruction[24:20];
    assign write_sel = instruction[11:7];
    assign imm12     = instruction[31:20];
    assign pc_o      = pc;
    assign pc_next_o = pc_next;

    rv32_imm_gen u_imm_gen (
        .instruction (instruction),
        .imm32       (imm32)
    );

    assign target_pc = pc + ADDRESS_BITS'(imm32);

    // A squashed or reset cycle is a bubble: no writeback, no redirect.
    logic bubble;
    assign bubble = branch | reset;

    logic [NUM_WB_OPS-1:0] wb_hit;
    for (genvar gi = 0; gi < NUM_WB_OPS; gi++) begin : g_wb_match
        assign wb_hit[gi] = (op == WB_OPCODES[gi]);
    end

    assign wen = (|wb_hit) && (write_sel != 5'd0) && !bubble;

    logic is_jal;
    assign is_jal = (op == OP_JAL);

`ifdef DECODER_BRANCH_PREDICT_EN
    logic loop_exit_q;
    logic backward_branch;

    assign backward_branch = (op == OP_BRANCH) && imm32[31];

    // A pending loop exit suppresses exactly one backward-branch prediction.
    always_ff @(posedge clk) begin
        if (reset) begin
            loop_exit_q <= 1'b0;
        end else if (out_of_loop_i) begin
            loop_exit_q <= 1'b1;
        end else if (backward_branch && !branch) begin
            loop_exit_q <= 1'b0;
        end
    end

    assign pc_s_d = !bubble && (is_jal || (backward_branch && !loop_exit_q));
`else
    logic unused_predict_inputs;
    assign unused_predict_inputs = ^{clk, out_of_loop_i};

    assign pc_s_d = !bubble && is_jal;
`endif

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed-vector bench for rv32_decode_stage; expectations are hand-derived encodings.
// Prediction expectations follow whether DECODER_BRANCH_PREDICT_EN is defined.
module tb_rv32_decode_stage;

`ifdef DECODER_BRANCH_PREDICT_EN
    localparam logic PRED = 1'b1;
`else
    localparam logic PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] pc_next;
    logic        branch;
    logic        out_of_loop_i;
    logic [31:0] target_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        pc_s_d;
    logic [4:0]  read_sel1;
    logic [4:0]  read_sel2;
    logic [4:0]  write_sel;
    logic        wen;
    logic [31:0] imm32;
    logic [31:0] pc_next_o;
    logic [31:0] pc_o;
    logic [11:0] imm12;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32_decode_stage #(.ADDRESS_BITS(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .instruction   (instruction),
        .pc_next       (pc_next),
        .branch        (branch),
        .out_of_loop_i (out_of_loop_i),
        .target_pc     (target_pc),
        .op            (op),
        .funct3        (funct3),
        .funct7        (funct7),
        .pc_s_d        (pc_s_d),
        .read_sel1     (read_sel1),
        .read_sel2     (read_sel2),
        .write_sel     (write_sel),
        .wen           (wen),
        .imm32         (imm32),
        .pc_next_o     (pc_next_o),
        .pc_o          (pc_o),
        .imm12         (imm12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an instruction mid-cycle and let combinational outputs settle.
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc_val);
        @(negedge clk);
        instruction = instr;
        pc          = pc_val;
        pc_next     = pc_val + 32'd4;
        #1;
        $display("instr=0x%08h pc=0x%08h -> op=0x%02h imm32=0x%08h tgt=0x%08h wen=%0b pc_s_d=%0b",
                 instr, pc_val, op, imm32, target_pc, wen, pc_s_d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; branch = 1'b0; out_of_loop_i = 1'b0;
        instruction = 32'h0070_8093; pc = 32'h0; pc_next = 32'h4;
        tick(); tick();
        check("reset_wen", {31'd0, wen}, 32'd0);
        check("reset_pc_s_d", {31'd0, pc_s_d}, 32'd0);
        // jal under reset still must not redirect
        drive(32'h0500_036F, 32'h0);
        check("reset_jal_pc_s_d", {31'd0, pc_s_d}, 32'd0);
        @(negedge clk); reset = 1'b0;

        // addi x1,x1,7
        drive(32'h0070_8093, 32'h100);
        check("addi_op", {25'd0, op}, 32'h13);
        check("addi_rs1", {27'd0, read_sel1}, 32'd1);
        check("addi_rd", {27'd0, write_sel}, 32'd1);
        check("addi_wen", {31'd0, wen}, 32'd1);
        check("addi_imm32", imm32, 32'd7);
        check("addi_imm12", {20'd0, imm12}, 32'h007);
        check("addi_pc_s_d", {31'd0, pc_s_d}, 32'd0);
        check("addi_pc_o", pc_o, 32'h100);
        check("addi_pc_next_o", pc_next_o, 32'h104);

        // sub x4,x1,x2
        drive(32'h4020_8233, 32'h104);
        check("sub_funct7", {25'd0, funct7}, 32'h20);
        check("sub_funct3", {29'd0, funct3}, 32'd0);
        check("sub_rs1", {27'd0, read_sel1}, 32'd1);
        check("sub_rs2", {27'd0, read_sel2}, 32'd2);
        check("sub_rd", {27'd0, write_sel}, 32'd4);
        check("sub_wen", {31'd0, wen}, 32'd1);
        check("sub_imm32", imm32, 32'd0);

        // sw x8,8(x19)
        drive(32'h0089_A423, 32'h108);
        check("sw_rs1", {27'd0, read_sel1}, 32'd19);
        check("sw_rs2", {27'd0, read_sel2}, 32'd8);
        check("sw_imm32", imm32, 32'd8);
        check("sw_wen", {31'd0, wen}, 32'd0);

        drive(32'h0000_0013, 32'h10C);
        check("nop_wen", {31'd0, wen}, 32'd0);

        // lw x1,-1(x2): negative I immediate
        drive(32'hFFF1_2083, 32'h110);
        check("lw_imm32", imm32, 32'hFFFF_FFFF);
        check("lw_imm12", {20'd0, imm12}, 32'hFFF);

        // lui x5,0x12345
        drive(32'h1234_52B7, 32'h114);
        check("lui_imm32", imm32, 32'h1234_5000);
        check("lui_wen", {31'd0, wen}, 32'd1);

        // jalr x1,0(x1): writes rd, never predicted
        drive(32'h0000_80E7, 32'h118);
        check("jalr_wen", {31'd0, wen}, 32'd1);
        check("jalr_pc_s_d", {31'd0, pc_s_d}, 32'd0);

        // custom-0 rd=x1, and an unknown opcode with rd=x1
        drive(32'h0000_008B, 32'h11C);
        check("custom0_wen", {31'd0, wen}, 32'd1);
        check("custom0_imm32", imm32, 32'd0);
        drive(32'h0000_00FF, 32'h120);
        check("unknown_wen", {31'd0, wen}, 32'd0);

        // beq forward
        drive(32'h0002_0463, 32'h14);
        check("beq_fwd_target", target_pc, 32'h1C);
        check("beq_fwd_pc_s_d", {31'd0, pc_s_d}, 32'd0);
        check("beq_fwd_wen", {31'd0, wen}, 32'd0);

        // jal x6,0x50
        drive(32'h0500_036F, 32'h0);
        check("jal_target", target_pc, 32'h50);
        check("jal_pc_s_d", {31'd0, pc_s_d}, 32'd1);
        check("jal_rd", {27'd0, write_sel}, 32'd6);
        check("jal_wen", {31'd0, wen}, 32'd1);

        // target wraps modulo 2^32
        drive(32'h0500_036F, 32'hFFFF_FFF0);
        check("jal_wrap_target", target_pc, 32'h40);

        // squash: branch=1 bubbles addi and jal
        @(negedge clk); branch = 1'b1;
        drive(32'h0070_8093, 32'h200);
        check("squash_addi_wen", {31'd0, wen}, 32'd0);
        check("squash_addi_rd", {27'd0, write_sel}, 32'd1);
        drive(32'h0500_036F, 32'h204);
        check("squash_jal_pc_s_d", {31'd0, pc_s_d}, 32'd0);
        @(negedge clk); branch = 1'b0;

        // beq x0,x0,-4 at 0x20
        drive(32'hFE00_0EE3, 32'h20);
        check("beq_back_target", target_pc, 32'h1C);
        check("beq_back_imm32", imm32, 32'hFFFF_FFFC);
        check("beq_back_pred", {31'd0, pc_s_d}, {31'd0, PRED});

        // loop exit pulse: suppress once, then clear on the following edge
        @(negedge clk); out_of_loop_i = 1'b1;
        tick();
        @(negedge clk); out_of_loop_i = 1'b0;
        #1;
        check("loop_exit_suppress", {31'd0, pc_s_d}, 32'd0);
        tick();
        check("loop_exit_cleared", {31'd0, pc_s_d}, {31'd0, PRED});

        // squashed backward branch must not consume a pending loop exit
        @(negedge clk); out_of_loop_i = 1'b1;
        tick();
        @(negedge clk); out_of_loop_i = 1'b0; branch = 1'b1;
        tick();
        @(negedge clk); branch = 1'b0;
        #1;
        check("loop_exit_held_on_squash", {31'd0, pc_s_d}, 32'd0);

        // reset clears a pending loop exit
        @(negedge clk); reset = 1'b1;
        #1;
        check("reset_beq_pc_s_d", {31'd0, pc_s_d}, 32'd0);
        tick();
        @(negedge clk); reset = 1'b0;
        #1;
        check("reset_clears_loop_exit", {31'd0, pc_s_d}, {31'd0, PRED});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
